hdmi_pixel_packer: RTL and testbench

//  Upstream stage of the LCD FIFO. Takes the 24-bit RGB pixel stream from the HDMI receiver,

---
 rtl/hdmi_pixel_packer_pkg.sv | 23 ++
 rtl/hdmi_pixel_packer_luma.sv | 33 +++
 rtl/hdmi_pixel_packer.sv | 165 ++++++++++++++++
 tb/tb_hdmi_pixel_packer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pixel_packer_pkg.sv
// Shared constants for the HDMI -> 1 bit/pixel packer: state encoding, luma weights
// and line geometry helpers.
package hdmi_pixel_packer_pkg;

  localparam logic [1:0] s_IDLE       = 2'd0;
  localparam logic [1:0] s_WAIT_FRAME = 2'd1;
  localparam logic [1:0] s_ACTIVE     = 2'd2;
  localparam logic [1:0] s_DROP       = 2'd3;

  // Y = (2R + 5G + B) >> 3
  localparam logic [2:0] LUMA_WR = 3'd2;
  localparam logic [2:0] LUMA_WG = 3'd5;
  localparam logic [2:0] LUMA_WB = 3'd1;

  localparam int PACK_W = 32;

  function automatic int line_words(input int pixels);
    return pixels / PACK_W;
  endfunction

  localparam int LINE_WORDS = line_words(1280);

endpackage

// File: rtl/hdmi_pixel_packer_luma.sv
// Stage 1 of the packer: registered RGB -> luma -> 1-bit threshold, with its valid.
module luma_threshold
  import hdmi_pixel_packer_pkg::*;
#(
  parameter logic [7:0] THRESHOLD = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_p0,
  input  logic        vld_p0,
  output logic        bit_p1,
  output logic        vld_p1
);

  function automatic logic [7:0] luma(input logic [23:0] rgb);
    logic [10:0] sum;
    sum = 11'(LUMA_WR) * {3'b000, rgb[23:16]}
        + 11'(LUMA_WG) * {3'b000, rgb[15:8]}
        + 11'(LUMA_WB) * {3'b000, rgb[7:0]};
    return sum[10:3];
  endfunction

  // p0 -> p1 boundary
  always_ff @(posedge clk) begin
    bit_p1 <= (luma(rgb_p0) >= THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

endmodule

// File: rtl/hdmi_pixel_packer.sv
// Converts the HDMI RGB stream to 1 bit/pixel and packs 32 pixels per FIFO word,
// frame-aligned on vSync; overflow drops the remainder of the frame.
module hdmi_pixel_packer
  import hdmi_pixel_packer_pkg::*;
#(
  parameter int         PIXELS_PER_LINE  = 1280,
  parameter int         LINES_PER_FRAME  = 1280,
  parameter logic [7:0] THRESHOLD        = 8'd128,
  parameter bit         SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [23:0] i_hdmiData,
  input  logic        i_hSync,
  input  logic        i_vSync,
  input  logic        i_dataEnable,
  input  logic        i_hdmiEnable,
  input  logic        i_fifoFull,
  output logic [31:0] o_fifoData,
  output logic        o_dataValid,
  output logic        o_frameStart,
  output logic        o_overflow,
  output logic        o_lineError
);

  localparam int WORDS_PER_LINE = line_words(PIXELS_PER_LINE);
  localparam int WCNT_W = $clog2(WORDS_PER_LINE + 1);
  localparam int LCNT_W = $clog2(LINES_PER_FRAME + 1);

  logic              bit_p1;
  logic              vld_p1;
  logic              vs_p1;
  logic              vs_p2;
  logic              de_p2;
  logic [1:0]        state;
  logic [31:0]       shreg;
  logic [4:0]        pix_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [LCNT_W-1:0] line_cnt;
  logic              frame_pend;

  // Line boundaries come from the dataEnable falling edge, so hSync carries no information here.
  logic hsync_unused;
  assign hsync_unused = i_hSync;

  luma_threshold #(.THRESHOLD(THRESHOLD)) u_luma (
    .clk    (i_clock),
    .rst    (i_reset),
    .rgb_p0 (i_hdmiData),
    .vld_p0 (i_dataEnable),
    .bit_p1 (bit_p1),
    .vld_p1 (vld_p1)
  );

  // Sync copies delayed to line up with the stage-1 pixel bit
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vs_p1 <= 1'b0;
      vs_p2 <= 1'b0;
      de_p2 <= 1'b0;
    end else begin
      vs_p1 <= (i_vSync == SYNC_ACTIVE_HIGH);
      vs_p2 <= vs_p1;
      de_p2 <= vld_p1;
    end
  end

  logic        vs_edge;
  logic        de_fall;
  logic        line_full;
  logic        pix_take;
  logic        active;
  logic        word_rdy;
  logic [31:0] word_next;
  logic [31:0] flush_word;
  logic [31:0] word_val;

  assign vs_edge    = vs_p2 & ~vs_p1;
  assign de_fall    = de_p2 & ~vld_p1;
  assign line_full  = (word_cnt == WCNT_W'(WORDS_PER_LINE));
  assign active     = (state == s_ACTIVE) & i_hdmiEnable & ~vs_edge;
  assign pix_take   = vld_p1 & ~line_full;
  assign word_next  = {shreg[30:0], bit_p1};
  assign flush_word = shreg << (6'd32 - {1'b0, pix_cnt});
  assign word_rdy   = active & ((pix_take & (pix_cnt == 5'd31)) | (de_fall & (pix_cnt != 5'd0)));
  assign word_val   = de_fall ? flush_word : word_next;

  // Stage 2: FSM, counters, shift register and FIFO write port
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= s_WAIT_FRAME;
      shreg        <= '0;
      pix_cnt      <= '0;
      word_cnt     <= '0;
      line_cnt     <= '0;
      frame_pend   <= 1'b1;
      o_fifoData   <= '0;
      o_dataValid  <= 1'b0;
      o_frameStart <= 1'b0;
      o_overflow   <= 1'b0;
      o_lineError  <= 1'b0;
    end else begin
      o_dataValid  <= 1'b0;
      o_frameStart <= 1'b0;

      if (!i_hdmiEnable) begin
        state <= s_IDLE;
      end else begin
        case (state)
          s_IDLE: state <= s_WAIT_FRAME;
          s_WAIT_FRAME, s_DROP: begin
            if (vs_edge) begin
              state      <= s_ACTIVE;
              shreg      <= '0;
              pix_cnt    <= '0;
              word_cnt   <= '0;
              line_cnt   <= '0;
              frame_pend <= 1'b1;
            end
          end
          default: begin
            if (vs_edge) begin
              // Frame ended early: report it and realign on the new frame.
              o_lineError <= 1'b1;
              shreg       <= '0;
              pix_cnt     <= '0;
              word_cnt    <= '0;
              line_cnt    <= '0;
              frame_pend  <= 1'b1;
            end else begin
              if (pix_take) begin
                shreg   <= word_next;
                pix_cnt <= pix_cnt + 5'd1;
                if (pix_cnt == 5'd31) word_cnt <= word_cnt + 1'b1;
              end else if (vld_p1) begin
                o_lineError <= 1'b1;
              end
              if (de_fall) begin
                if ((pix_cnt != 5'd0) || !line_full) o_lineError <= 1'b1;
                shreg    <= '0;
                pix_cnt  <= '0;
                word_cnt <= '0;
                line_cnt <= line_cnt + 1'b1;
                if (line_cnt == LCNT_W'(LINES_PER_FRAME - 1)) state <= s_WAIT_FRAME;
              end
            end
          end
        endcase
      end

      if (word_rdy) begin
        if (i_fifoFull) begin
          o_overflow <= 1'b1;
          state      <= s_DROP;
        end else begin
          o_fifoData   <= word_val;
          o_dataValid  <= 1'b1;
          o_frameStart <= frame_pend;
          frame_pend   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_packer.sv
// Directed bench for hdmi_pixel_packer on a reduced 64x4 geometry (2 words per line).
module tb_hdmi_pixel_packer;

  localparam int PPL   = 64;
  localparam int LINES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] hdmi_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        hdmi_en;
  logic        fifo_full;
  logic [31:0] fifo_data;
  logic        data_valid;
  logic        frame_start;
  logic        overflow;
  logic        line_error;

  hdmi_pixel_packer #(
    .PIXELS_PER_LINE  (PPL),
    .LINES_PER_FRAME  (LINES),
    .THRESHOLD        (8'd128),
    .SYNC_ACTIVE_HIGH (1'b1)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_hdmiData   (hdmi_data),
    .i_hSync      (hsync),
    .i_vSync      (vsync),
    .i_dataEnable (de),
    .i_hdmiEnable (hdmi_en),
    .i_fifoFull   (fifo_full),
    .o_fifoData   (fifo_data),
    .o_dataValid  (data_valid),
    .o_frameStart (frame_start),
    .o_overflow   (overflow),
    .o_lineError  (line_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] cap_data[$];
  logic        cap_fs[$];
  int          cap_cyc[$];

  always @(negedge clk) begin
    if (data_valid) begin
      cap_data.push_back(fifo_data);
      cap_fs.push_back(frame_start);
      cap_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int grp_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [23:0] pix(input int mode, input int i);
    case (mode)
      0:       return 24'hFFFFFF;
      1:       return (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      default: return (i % 4 == 0) ? 24'h808080 : 24'h7F7F7F;
    endcase
  endfunction

  task automatic send_line(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      hdmi_data = pix(mode, i);
      de = 1'b1;
      if (i == 31) grp_cyc = cyc;
      step();
    end
    de = 1'b0;
    hdmi_data = 24'h0;
    step(4);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(2);
  endtask

  task automatic send_frame(input int mode);
    vsync_pulse();
    for (int l = 0; l < LINES; l++) send_line(PPL, mode);
    step(6);
  endtask

  function automatic int n_bad(input int from, input logic [31:0] exp);
    int b = 0;
    for (int j = from; j < cap_data.size(); j++) if (cap_data[j] !== exp) b++;
    return b;
  endfunction

  function automatic int n_fs(input int from);
    int c = 0;
    for (int j = from; j < cap_fs.size(); j++) if (cap_fs[j]) c++;
    return c;
  endfunction

  int base;

  initial begin
    rst = 1'b1; hdmi_data = '0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
    hdmi_en = 1'b1; fifo_full = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);

    // reset state
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", fifo_data, 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_lerr", 32'(line_error), 32'd0);

    // all-white frame
    base = cap_data.size();
    send_frame(0);
    check("white_cnt", 32'(cap_data.size() - base), 32'd8);
    check("white_bad", 32'(n_bad(base, 32'hFFFFFFFF)), 32'd0);
    check("white_fs_cnt", 32'(n_fs(base)), 32'd1);
    check("white_fs_first", 32'(cap_fs[base]), 32'd1);
    check("white_ovf", 32'(overflow), 32'd0);
    check("white_lerr", 32'(line_error), 32'd0);

    // alternating pixels
    base = cap_data.size();
    send_frame(1);
    check("alt_cnt", 32'(cap_data.size() - base), 32'd8);
    check("alt_bad", 32'(n_bad(base, 32'hAAAAAAAA)), 32'd0);
    check("alt_fs_first", 32'(cap_fs[base]), 32'd1);
    check("alt_latency", 32'(cap_cyc[base + 6] - grp_cyc), 32'd2);

    // threshold edge: gray 128 -> 1, gray 127 -> 0, pattern 1000
    base = cap_data.size();
    send_frame(2);
    check("thr_cnt", 32'(cap_data.size() - base), 32'd8);
    check("thr_bad", 32'(n_bad(base, 32'h88888888)), 32'd0);

    // FIFO full at word 4 drops the rest of the frame
    base = cap_data.size();
    vsync_pulse();
    send_line(PPL, 0);
    send_line(PPL, 0);
    fifo_full = 1'b1;
    send_line(PPL, 0);
    fifo_full = 1'b0;
    send_line(PPL, 0);
    step(6);
    check("ovf_cnt", 32'(cap_data.size() - base), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    base = cap_data.size();
    send_frame(0);
    check("ovf_next_cnt", 32'(cap_data.size() - base), 32'd8);
    check("ovf_next_fs", 32'(cap_fs[base]), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // long line then short line
    check("len_lerr_pre", 32'(line_error), 32'd0);
    base = cap_data.size();
    vsync_pulse();
    send_line(PPL + 6, 0);
    send_line(PPL - 10, 0);
    send_line(PPL, 0);
    send_line(PPL, 0);
    step(6);
    check("len_cnt", 32'(cap_data.size() - base), 32'd8);
    check("len_long_w1", cap_data[base + 1], 32'hFFFFFFFF);
    check("len_short_w0", cap_data[base + 2], 32'hFFFFFFFF);
    check("len_short_pad", cap_data[base + 3], 32'hFFFFFC00);
    check("len_lerr", 32'(line_error), 32'd1);

    // reset at pixel 17 of the second group
    vsync_pulse();
    for (int i = 0; i < 49; i++) begin
      hdmi_data = 24'hFFFFFF; de = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_data", fifo_data, 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_lerr", 32'(line_error), 32'd0);
    base = cap_data.size();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) step();
    de = 1'b0;
    step(4);
    send_line(PPL, 0);
    send_line(PPL, 0);
    step(6);
    check("mid_rst_nowrite", 32'(cap_data.size() - base), 32'd0);
    base = cap_data.size();
    send_frame(0);
    check("mid_rst_resume", 32'(cap_data.size() - base), 32'd8);
    check("mid_rst_fs", 32'(cap_fs[base]), 32'd1);

    // enable dropped mid-frame
    base = cap_data.size();
    vsync_pulse();
    send_line(PPL, 0);
    hdmi_en = 1'b0;
    send_line(PPL, 0);
    hdmi_en = 1'b1;
    send_line(PPL, 0);
    send_line(PPL, 0);
    step(6);
    check("en_cnt", 32'(cap_data.size() - base), 32'd2);
    base = cap_data.size();
    send_frame(1);
    check("en_resume", 32'(cap_data.size() - base), 32'd8);
    check("en_fs", 32'(cap_fs[base]), 32'd1);
    check("en_lerr", 32'(line_error), 32'd0);

    // vSync after only two lines restarts the frame
    base = cap_data.size();
    vsync_pulse();
    send_line(PPL, 0);
    send_line(PPL, 0);
    send_frame(0);
    check("early_cnt", 32'(cap_data.size() - base), 32'd12);
    check("early_fs_cnt", 32'(n_fs(base)), 32'd2);
    check("early_lerr", 32'(line_error), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
